// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared encodings, state type and alignment check for data_mem_responder
package mem_resp_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam logic [63:0] LED_ADDR_DEFAULT = 64'h1000;

  // Prefixed so the wait state cannot collide with the WAIT latency parameter.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic alignErr(input logic [1:0] size, input logic [2:0] a);
    case (size)
      SZ_H:    return a[0];
      SZ_W:    return |a[1:0];
      SZ_D:    return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response handshake bundle between MEM stage and data memory
interface data_mem_responder_if #(
  parameter int Nbits = 64
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [Nbits-1:0] req_addr;
  logic [Nbits-1:0] req_wdata;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [Nbits-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - little-endian byte-lane merge for stores and extract/extend for loads
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [63:0] oldDw,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  output logic [63:0] mergedDw,
  output logic [63:0] loadVal
);

  logic [5:0]  bitOff;
  logic [3:0]  nBytes;
  logic [7:0]  byteEn;
  logic [63:0] bitMask;
  logic [63:0] ext;
  logic        sgn;

  always_comb begin
    bitOff = {off, 3'b000};
    nBytes = 4'd1 << size;
    byteEn = '0;
    bitMask = '0;
    for (int i = 0; i < 8; i++) begin
      byteEn[i] = (4'(i) >= {1'b0, off}) && (4'(i) < ({1'b0, off} + nBytes));
      bitMask[i*8 +: 8] = {8{byteEn[i]}};
    end
    mergedDw = (oldDw & ~bitMask) | ((wdata << bitOff) & bitMask);

    ext = oldDw >> bitOff;
    sgn = ~isUnsigned;
    case (size)
      SZ_B:    loadVal = {{56{sgn & ext[7]}}, ext[7:0]};
      SZ_H:    loadVal = {{48{sgn & ext[15]}}, ext[15:0]};
      SZ_W:    loadVal = {{32{sgn & ext[31]}}, ext[31:0]};
      default: loadVal = ext;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated doubleword RAM responder with one memory-mapped LED register
module data_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int               Nbits    = 64,
  parameter int               DEPTH    = 256,
  parameter int               WAIT     = 2,
  parameter logic [Nbits-1:0] LED_ADDR = Nbits'(LED_ADDR_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  data_mem_responder_if.slave bus,
  output logic led
);

  localparam int         IDXW     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  state_t           state;
  logic [3:0]       cnt;
  logic             wrL;
  logic [Nbits-1:0] addrL;
  logic [Nbits-1:0] wdataL;
  logic [1:0]       sizeL;
  logic             unsL;
  logic             rspValid;
  logic             rspErr;
  logic [Nbits-1:0] rspRdata;
  logic             ledQ;

  logic [63:0] mem [DEPTH];

  logic             isIdle;
  logic             accept;
  logic             doAccess;
  logic             accW;
  logic [Nbits-1:0] accAddr;
  logic [Nbits-1:0] accWdata;
  logic [1:0]       accSize;
  logic             accUns;
  logic [IDXW-1:0]  ramIdx;
  logic             ramHit;
  logic             ledHit;
  logic             accErr;
  logic             ramWe;
  logic [63:0]      oldDw;
  logic [63:0]      mergedDw;
  logic [63:0]      loadVal;

  // With zero wait states the access happens on the acceptance edge, so the
  // access path must see the live bus rather than the latched copy.
  always_comb begin
    isIdle   = (state == ST_IDLE);
    accept   = isIdle & bus.req_valid;
    accW     = isIdle ? bus.req_write    : wrL;
    accAddr  = isIdle ? bus.req_addr     : addrL;
    accWdata = isIdle ? bus.req_wdata    : wdataL;
    accSize  = isIdle ? bus.req_size     : sizeL;
    accUns   = isIdle ? bus.req_unsigned : unsL;
    doAccess = (accept && (WAIT == 0)) || ((state == ST_WAIT) && (cnt == 4'd0));
    ramIdx   = accAddr[IDXW+2:3];
    ramHit   = (accAddr >> 3) < Nbits'(DEPTH);
    ledHit   = (accAddr == LED_ADDR);
    accErr   = alignErr(accSize, accAddr[2:0]) | ~(ramHit | ledHit);
    oldDw    = mem[ramIdx];
    ramWe    = rst & doAccess & accW & ~accErr & ramHit;
  end

  mem_lane_align u_lane (
    .oldDw      (oldDw),
    .wdata      (accWdata),
    .off        (accAddr[2:0]),
    .size       (accSize),
    .isUnsigned (accUns),
    .mergedDw   (mergedDw),
    .loadVal    (loadVal)
  );

  always_ff @(posedge clk) begin
    if (ramWe) mem[ramIdx] <= mergedDw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      wrL      <= 1'b0;
      addrL    <= '0;
      wdataL   <= '0;
      sizeL    <= 2'b00;
      unsL     <= 1'b0;
      rspValid <= 1'b0;
      rspErr   <= 1'b0;
      rspRdata <= '0;
      ledQ     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wrL    <= bus.req_write;
            addrL  <= bus.req_addr;
            wdataL <= bus.req_wdata;
            sizeL  <= bus.req_size;
            unsL   <= bus.req_unsigned;
            cnt    <= WAIT_CNT;
            state  <= (WAIT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) state <= ST_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state    <= ST_IDLE;
            rspValid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (doAccess) begin
        rspValid <= 1'b1;
        rspErr   <= accErr;
        if (accW || accErr)  rspRdata <= '0;
        else if (ledHit)     rspRdata <= {{(Nbits-1){1'b0}}, ledQ};
        else                 rspRdata <= loadVal;
        if (accW && !accErr && ledHit) ledQ <= accWdata[0];
      end
    end
  end

  assign bus.req_ready = isIdle;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_err   = rspErr;
  assign bus.rsp_rdata = rspRdata;
  assign led           = ledQ;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
  import mem_resp_pkg::*;

  localparam int          WAITS = 2;
  localparam logic [63:0] LEDA  = 64'h1000;
  localparam int          NVEC  = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic led;

  always #5 clk = ~clk;

  data_mem_responder_if #(.Nbits(64)) bus ();

  data_mem_responder #(
    .Nbits    (64),
    .DEPTH    (256),
    .WAIT     (WAITS),
    .LED_ADDR (LEDA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .led (led)
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] expData;
    logic        expErr;
    logic        expLed;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[NVEC];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [1:0] size, input logic uns, input logic [63:0] expData,
                              input logic expErr, input logic expLed);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.expData = expData; v.expErr = expErr; v.expLed = expLed;
    return v;
  endfunction

  // Scoreboard consumer: compares each response at the negedge before its handshake edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got rsp %h with empty scoreboard", bus.rsp_rdata);
      end else begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.data);
        chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.req_write    = v.wr;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_valid    = 1'b1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_before_accept", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic waitRsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic doReq(input vec_t v);
    exp_t e;
    int   lat;
    drive(v);
    waitReady();
    @(posedge clk);
    e.data = v.expData;
    e.err  = v.expErr;
    sb.push_back(e);
    #1 bus.req_valid = 1'b0;
    waitRsp(lat);
    chk("latency", 64'(lat), 64'(WAITS + 1));
    chk("led_at_commit", 64'(led), 64'(v.expLed));
    @(posedge clk); #1;
    chk("rsp_valid_dropped", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   lat;
    logic [63:0] held;

    vecs[0]  = mk(1, 64'h10,   64'h0123_4567_89AB_CDEF, SZ_D, 0, 64'h0,                   0, 0);
    vecs[1]  = mk(0, 64'h10,   64'h0,                   SZ_D, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
    vecs[2]  = mk(1, 64'h13,   64'h80,                  SZ_B, 0, 64'h0,                   0, 0);
    vecs[3]  = mk(0, 64'h13,   64'h0,                   SZ_B, 0, 64'hFFFF_FFFF_FFFF_FF80, 0, 0);
    vecs[4]  = mk(0, 64'h13,   64'h0,                   SZ_B, 1, 64'h0000_0000_0000_0080, 0, 0);
    vecs[5]  = mk(0, 64'h10,   64'h0,                   SZ_D, 0, 64'h0123_4567_80AB_CDEF, 0, 0);
    vecs[6]  = mk(0, 64'h12,   64'h0,                   SZ_H, 0, 64'hFFFF_FFFF_FFFF_80AB, 0, 0);
    vecs[7]  = mk(0, 64'h14,   64'h0,                   SZ_W, 1, 64'h0000_0000_0123_4567, 0, 0);
    vecs[8]  = mk(0, 64'h10,   64'h0,                   SZ_W, 0, 64'hFFFF_FFFF_80AB_CDEF, 0, 0);
    vecs[9]  = mk(0, 64'h12,   64'h0,                   SZ_W, 0, 64'h0,                   1, 0);
    vecs[10] = mk(1, 64'h0,    64'hAAAA_5555_AAAA_5555, SZ_D, 0, 64'h0,                   0, 0);
    vecs[11] = mk(1, 64'h800,  64'hFFFF_FFFF_FFFF_FFFF, SZ_D, 0, 64'h0,                   1, 0);
    vecs[12] = mk(0, 64'h0,    64'h0,                   SZ_D, 0, 64'hAAAA_5555_AAAA_5555, 0, 0);
    vecs[13] = mk(1, 64'h18,   64'h1234_BEEF,           SZ_H, 0, 64'h0,                   0, 0);
    vecs[14] = mk(0, 64'h18,   64'h0,                   SZ_H, 1, 64'h0000_0000_0000_BEEF, 0, 0);
    vecs[15] = mk(1, LEDA,     64'h1,                   SZ_W, 0, 64'h0,                   0, 1);
    vecs[16] = mk(0, LEDA,     64'h0,                   SZ_D, 0, 64'h1,                   0, 1);
    vecs[17] = mk(0, LEDA + 1, 64'h0,                   SZ_B, 0, 64'h0,                   1, 1);
    vecs[18] = mk(1, LEDA,     64'hFE,                  SZ_B, 0, 64'h0,                   0, 0);
    vecs[19] = mk(0, LEDA,     64'h0,                   SZ_W, 1, 64'h0,                   0, 0);
    vecs[20] = mk(1, 64'h11,   64'hFFFF,                SZ_H, 0, 64'h0,                   1, 0);
    vecs[21] = mk(0, 64'h10,   64'h0,                   SZ_D, 1, 64'h0123_4567_80AB_CDEF, 0, 0);

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("reset_led", 64'(led), 64'd0);
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) doReq(vecs[i]);

    // Backpressure: response held for 5 cycles while a competing store is offered.
    bus.rsp_ready = 1'b0;
    drive(mk(0, 64'h10, 64'h0, SZ_D, 0, 64'h0, 0, 0));
    waitReady();
    @(posedge clk);
    e.data = 64'h0123_4567_80AB_CDEF;
    e.err  = 1'b0;
    sb.push_back(e);
    #1 bus.req_valid = 1'b0;
    waitRsp(lat);
    chk("bp_latency", 64'(lat), 64'(WAITS + 1));
    held = bus.rsp_rdata;
    drive(mk(1, 64'h10, 64'hDEAD_DEAD_DEAD_DEAD, SZ_D, 0, 64'h0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_rdata", bus.rsp_rdata, 64'h0123_4567_80AB_CDEF);
      chk("bp_rdata_stable", bus.rsp_rdata, held);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
    chk("bp_release_idle", 64'(bus.req_ready), 64'd1);
    doReq(mk(0, 64'h10, 64'h0, SZ_D, 0, 64'h0123_4567_80AB_CDEF, 0, 0));

    // Reset one cycle after a store is accepted: nothing may commit.
    doReq(mk(1, 64'h20, 64'h1111_2222_3333_4444, SZ_D, 0, 64'h0, 0, 0));
    doReq(mk(1, LEDA, 64'h1, SZ_D, 0, 64'h0, 0, 1));
    drive(mk(1, 64'h20, 64'hDEAD_BEEF_DEAD_BEEF, SZ_D, 0, 64'h0, 0, 0));
    waitReady();
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", 64'(bus.req_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("async_rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("async_rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("async_rst_led", 64'(led), 64'd0);
    chk("async_rst_req_ready", 64'(bus.req_ready), 64'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    doReq(mk(0, 64'h20, 64'h0, SZ_D, 0, 64'h1111_2222_3333_4444, 0, 0));
    doReq(mk(0, LEDA, 64'h0, SZ_D, 0, 64'h0, 0, 0));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
